pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Arbitrates the single line-granular physical-memory port between the instruction-side L1 miss path (I) and the data-side path (D), where D is the L1 D-cache or victim-cache writeback/fill path.
- Sits between the cache hierarchy and physical memory.
- Sequences one transaction at a time: grant, forward the pmem_read/pmem_write handshake, route pmem_resp back to the owner.
- Uses round-robin fairness on simultaneous requests.

Parameters:
- ADDR_W, 32, address width in bits.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  I-side line read request, held until i_resp.
- i_addr  in  ADDR_W  I-side line address.
- i_rdata  out  LINE_W  read line to I side; equals pmem_rdata.
- i_resp  out  1  I-side completion pulse.
- d_read  in  1  D-side line read request.
- d_write  in  1  D-side line write request.
- d_addr  in  ADDR_W  D-side line address.
- d_wdata  in  LINE_W  D-side write line.
- d_rdata  out  LINE_W  read line to D side; equals pmem_rdata.
- d_resp  out  1  D-side completion pulse.
- pmem_read  out  1  physical memory read.
- pmem_write  out  1  physical memory write.
- pmem_addr  out  ADDR_W  physical memory address.
- pmem_wdata  out  LINE_W  physical memory write line.
- pmem_rdata  in  LINE_W  physical memory read line.
- pmem_resp  in  1  physical memory completion, one-cycle pulse.

Behaviour:
- State register (async reset to IDLE): IDLE, SERVE_I, SERVE_D.
- last_grant register (async reset to I). Outputs are combinational from the registered state.
- Reset values: pmem_read=0, pmem_write=0, i_resp=0, d_resp=0, pmem_addr=0, pmem_wdata=0.
- IDLE:
  - All pmem and resp outputs are 0.
  - i_req=i_read; d_req=d_read|d_write.
  - Only i_req -> SERVE_I. Only d_req -> SERVE_D.
  - Both -> grant the side opposite last_grant (first conflict after reset goes to D).
  - Neither -> stay.
  - last_grant updates on the IDLE->SERVE_x edge.
- SERVE_I:
  - pmem_read=1, pmem_addr=i_addr.
  - i_resp=pmem_resp.
  - On pmem_resp -> IDLE.
- SERVE_D:
  - pmem_addr=d_addr, pmem_wdata=d_wdata.
  - pmem_write=d_write; pmem_read=d_read & ~d_write (write wins if both high).
  - d_resp=pmem_resp. On pmem_resp -> IDLE.
- Latency: a request seen in IDLE at edge N drives pmem from cycle N+1. Response passes through combinationally in the same cycle as pmem_resp.
- There is always one IDLE cycle between transactions, so back-to-back service of alternating requesters is 1 idle cycle + pmem latency.
- The non-granted resp is always 0. The non-granted requester's inputs are ignored and it keeps waiting.
- i_rdata and d_rdata are always driven from pmem_rdata; consumers qualify with their resp.
- A requester dropping its request while granted (protocol violation): the arbiter stays in SERVE_x with pmem_read/pmem_write low until pmem_resp or reset. It is not required to recover gracefully.
- Reset mid-transaction: state -> IDLE and pmem_read/pmem_write fall asynchronously. The in-flight pmem access is abandoned.
- pmem_resp while in IDLE is ignored, and no resp is generated.

Optional Feature:
- Macro: PMEM_ARB_PERF_EN.
- With the macro defined, add three outputs, each 32 bits: perf_i_grants, perf_d_grants, perf_conflicts.
  - perf_i_grants and perf_d_grants increment on each IDLE->SERVE_I or IDLE->SERVE_D transition.
  - perf_conflicts increments on each IDLE cycle with both i_req and d_req high that causes a grant.
  - All three wrap at 2^32 and async reset to 0.
- Without the macro, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Reset, then i_read=1, i_addr=0x1000, pmem_resp after 4 cycles -> SERVE_I from next cycle, pmem_read=1, pmem_addr=0x1000, i_resp pulses 1 cycle with pmem_resp, then IDLE.
- d_write=1, d_addr=0x2040, d_wdata=0xA5..A5 -> pmem_write=1, pmem_read=0, pmem_wdata=0xA5..A5, d_resp on pmem_resp, i_resp stays 0 throughout.
- i_read and d_read asserted together right after reset, both held -> D served first, then 1 IDLE cycle, then I. The next simultaneous conflict grants D again (alternation).
- d_read=1 and d_write=1 together -> pmem_write=1, pmem_read=0.
- Assert rst_n=0 mid-SERVE_D -> pmem_write drops with no clock edge, state IDLE. A subsequent i_read is served normally.
- With PMEM_ARB_PERF_EN, 3 I-only, 2 D-only and 2 conflicting requests (each conflict cycle grants one side; the loser is served afterward) -> perf_i_grants=5, perf_d_grants=4, perf_conflicts=2.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one line-granular physical-memory port between the I-side and D-side miss paths.
// Optional performance counters (grant and conflict counts) are built when PMEM_ARB_PERF_EN is defined.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef PMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_conflicts
`endif
);

  // Handshake: a requester raises read/write with a stable address (and data) and holds it
  // until its resp pulse; resp is pmem_resp passed through in the same cycle, so a side
  // must drop its request on the edge after resp or it is seen as a new request.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state, state_next;
  logic   last_grant, last_grant_next;
  logic   i_req, d_req;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_addr       = '0;
    pmem_wdata      = '0;
    i_resp          = 1'b0;
    d_resp          = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the side that did not win last time gets the port.
        if (i_req && d_req) begin
          if (last_grant == GRANT_I) begin
            state_next      = SERVE_D;
            last_grant_next = GRANT_D;
          end else begin
            state_next      = SERVE_I;
            last_grant_next = GRANT_I;
          end
        end else if (i_req) begin
          state_next      = SERVE_I;
          last_grant_next = GRANT_I;
        end else if (d_req) begin
          state_next      = SERVE_D;
          last_grant_next = GRANT_D;
        end
      end
      SERVE_I: begin
        pmem_read = i_read;
        pmem_addr = i_addr;
        i_resp    = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      SERVE_D: begin
        pmem_write = d_write;
        pmem_read  = d_read & ~d_write;
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
        d_resp     = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef PMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else if (state == IDLE) begin
      if (state_next == SERVE_I) perf_i_grants <= perf_i_grants + 32'd1;
      if (state_next == SERVE_D) perf_d_grants <= perf_d_grants + 32'd1;
      if (i_req && d_req) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a latency-programmable memory responder, a response scoreboard and
// scenario tasks; define PMEM_ARB_PERF_EN to also exercise the performance counters.
module tb_pmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int EXP_W  = 3 + ADDR_W + LINE_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] i_rdata, d_rdata;
  logic              i_resp, d_resp;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
`ifdef PMEM_ARB_PERF_EN
  logic [31:0]       perf_i_grants, perf_d_grants, perf_conflicts;
`endif

  int unsigned       vectors = 0;
  int unsigned       miscompares = 0;
  logic [EXP_W-1:0]  exp_q[$];
  int                lat = 4;
  int                busy_cnt = 0;
  logic              model_last = 1'b0;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef PMEM_ARB_PERF_EN
    ,
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n   = 1'b0;
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- memory model ----------------
  function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  // Responds lat cycles after it first sees an access; pmem_resp lasts one cycle.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pmem_resp = 1'b0;
      busy_cnt  = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
      busy_cnt  = 0;
    end else if (pmem_read || pmem_write) begin
      busy_cnt++;
      if (busy_cnt >= lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_line(pmem_addr);
      end
    end else begin
      busy_cnt = 0;
    end
  end

  function automatic logic [EXP_W-1:0] make_exp(input logic side, input logic wr,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [LINE_W-1:0] wd);
    if (wr) return {side, 1'b1, 1'b0, a, wd};
    return {side, 1'b0, 1'b1, a, mem_line(a)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] obs, exp_v;
    if (rst_n && (i_resp || d_resp)) begin
      obs = {d_resp, pmem_write, pmem_read, pmem_addr,
             pmem_write ? pmem_wdata : (d_resp ? d_rdata : i_rdata)};
      vectors++;
      if (i_resp && d_resp) begin
        miscompares++;
        $display("FAIL both_resp: i_resp=%b d_resp=%b required one-hot", i_resp, d_resp);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got %h with no pending expectation", obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL resp_txn: got %h required %h", obs, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_resp(input logic side, output logic ok, output logic other_seen);
    ok = 1'b0;
    other_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (side ? i_resp : d_resp) other_seen = 1'b1;
      if (side ? d_resp : i_resp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_single(input logic side, input logic rd, input logic wr,
                           input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
    logic ok, other;
    @(posedge clk);
    #1;
    if (side) begin
      d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
      exp_q.push_back(make_exp(1'b1, wr, a, wd));
    end else begin
      i_read = 1'b1; i_addr = a;
      exp_q.push_back(make_exp(1'b0, 1'b0, a, '0));
    end
    wait_resp(side, ok, other);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_timeout: side=%0d resp=0 required 1 within 40 cycles", side);
    end
    @(posedge clk);
    #1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    model_last = side;
  endtask

  // Both sides request together; winner is predicted from the bench's own round-robin model.
  task automatic do_conflict(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                             output logic [ADDR_W-1:0] first_addr);
    logic ok, other, win;
    win = ~model_last;
    @(posedge clk);
    #1;
    i_read = 1'b1; i_addr = ia;
    d_read = 1'b1; d_addr = da; d_write = 1'b0;
    exp_q.push_back(win ? make_exp(1'b1, 1'b0, da, '0) : make_exp(1'b0, 1'b0, ia, '0));
    exp_q.push_back(win ? make_exp(1'b0, 1'b0, ia, '0) : make_exp(1'b1, 1'b0, da, '0));
    @(negedge clk);
    @(negedge clk);
    first_addr = pmem_addr;
    for (int k = 0; k < 2; k++) begin
      wait_resp(k == 0 ? win : ~win, ok, other);
      vectors++;
      if (!ok || other) begin
        miscompares++;
        $display("FAIL conflict_leg%0d: ok=%b other_resp=%b required ok=1 other_resp=0", k, ok, other);
      end
      @(posedge clk);
      #1;
      if ((k == 0) == win) d_read = 1'b0;
      else i_read = 1'b0;
    end
    model_last = ~win;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;
    #3;
    vectors++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: rd/wr/iresp/dresp=%b required 0000",
               {pmem_read, pmem_write, i_resp, d_resp});
    end
    vectors++;
    if (pmem_addr !== '0 || pmem_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 0", pmem_addr, pmem_wdata);
    end
    apply_reset();
  endtask

  task automatic test_i_read();
    logic ok, other;
    lat = 4;
    @(posedge clk);
    #1;
    i_read = 1'b1; i_addr = 32'h0000_1000;
    exp_q.push_back(make_exp(1'b0, 1'b0, 32'h0000_1000, '0));
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL i_latency_idle: pmem_read=%b required 0", pmem_read);
    end
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_1000 || i_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL i_serve: read=%b addr=%h resp=%b required 1 00001000 0",
               pmem_read, pmem_addr, i_resp);
    end
    wait_resp(1'b0, ok, other);
    vectors++;
    if (!ok || other) begin
      miscompares++;
      $display("FAIL i_resp_wait: ok=%b d_seen=%b required 1 0", ok, other);
    end
    @(posedge clk);
    #1 i_read = 1'b0;
    model_last = 1'b0;
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL i_back_idle: read=%b resp=%b required 0 0", pmem_read, i_resp);
    end
  endtask

  task automatic test_d_write();
    logic ok, other;
    lat = $urandom_range(2, 5);
    @(posedge clk);
    #1;
    d_write = 1'b1; d_addr = 32'h0000_2040; d_wdata = {32{8'hA5}};
    exp_q.push_back(make_exp(1'b1, 1'b1, 32'h0000_2040, {32{8'hA5}}));
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_wdata !== {32{8'hA5}}) begin
      miscompares++;
      $display("FAIL d_write_bus: wr=%b rd=%b wdata=%h required 1 0 a5..a5",
               pmem_write, pmem_read, pmem_wdata);
    end
    wait_resp(1'b1, ok, other);
    vectors++;
    if (!ok || other) begin
      miscompares++;
      $display("FAIL d_write_resp: ok=%b i_resp_seen=%b required 1 0", ok, other);
    end
    @(posedge clk);
    #1 d_write = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_conflict();
    logic ok, other;
    logic [ADDR_W-1:0] first;
    apply_reset();
    lat = $urandom_range(2, 5);
    @(posedge clk);
    #1;
    i_read = 1'b1; i_addr = 32'h0000_3000;
    d_read = 1'b1; d_addr = 32'h0000_4000;
    exp_q.push_back(make_exp(1'b1, 1'b0, 32'h0000_4000, '0));
    exp_q.push_back(make_exp(1'b0, 1'b0, 32'h0000_3000, '0));
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_4000) begin
      miscompares++;
      $display("FAIL conflict_first_d: read=%b addr=%h required 1 00004000", pmem_read, pmem_addr);
    end
    wait_resp(1'b1, ok, other);
    vectors++;
    if (!ok || other) begin
      miscompares++;
      $display("FAIL conflict_d_resp: ok=%b i_seen=%b required 1 0", ok, other);
    end
    @(posedge clk);
    #1 d_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_gap: pmem_read=%b required 0", pmem_read);
    end
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_3000) begin
      miscompares++;
      $display("FAIL conflict_then_i: read=%b addr=%h required 1 00003000", pmem_read, pmem_addr);
    end
    wait_resp(1'b0, ok, other);
    vectors++;
    if (!ok || other) begin
      miscompares++;
      $display("FAIL conflict_i_resp: ok=%b d_seen=%b required 1 0", ok, other);
    end
    @(posedge clk);
    #1 i_read = 1'b0;
    model_last = 1'b0;
    do_conflict(32'h0000_3100, 32'h0000_4100, first);
    vectors++;
    if (first !== 32'h0000_4100) begin
      miscompares++;
      $display("FAIL conflict_alternate: first addr=%h required 00004100", first);
    end
  endtask

  task automatic test_rw_and_random();
    logic [LINE_W-1:0] wd;
    logic              side, wr;
    lat = $urandom_range(2, 5);
    wd = {8{$urandom()}};
    do_single(1'b1, 1'b1, 1'b1, 32'h0000_7780, wd);
    for (int n = 0; n < 8; n++) begin
      lat  = $urandom_range(2, 5);
      side = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      wd   = {8{$urandom()}};
      do_single(side, ~wr, wr, $urandom() & 32'hFFFF_FFE0, wd);
    end
  endtask

  task automatic test_reset_mid();
    lat = 8;
    @(posedge clk);
    #1;
    d_write = 1'b1; d_addr = 32'h0000_5000; d_wdata = {8{$urandom()}};
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (pmem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre_write: pmem_write=%b required 1", pmem_write);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || pmem_addr !== '0) begin
      miscompares++;
      $display("FAIL mid_async_drop: wr=%b rd=%b addr=%h required 0 0 0",
               pmem_write, pmem_read, pmem_addr);
    end
    d_write = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_last = 1'b0;
    lat = $urandom_range(2, 5);
    do_single(1'b0, 1'b1, 1'b0, 32'h0000_6000, '0);
  endtask

`ifdef PMEM_ARB_PERF_EN
  task automatic test_perf();
    logic [ADDR_W-1:0] first;
    apply_reset();
    for (int n = 0; n < 3; n++) do_single(1'b0, 1'b1, 1'b0, 32'h0000_8000 + 32 * n, '0);
    do_single(1'b1, 1'b1, 1'b0, 32'h0000_9000, '0);
    do_single(1'b1, 1'b0, 1'b1, 32'h0000_9020, {8{$urandom()}});
    do_conflict(32'h0000_A000, 32'h0000_B000, first);
    do_conflict(32'h0000_A020, 32'h0000_B020, first);
    vectors++;
    if (perf_i_grants !== 32'd5 || perf_d_grants !== 32'd4 || perf_conflicts !== 32'd2) begin
      miscompares++;
      $display("FAIL perf_counts: i=%0d d=%0d c=%0d required 5 4 2",
               perf_i_grants, perf_d_grants, perf_conflicts);
    end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_conflict();
    test_rw_and_random();
    test_reset_mid();
`ifdef PMEM_ARB_PERF_EN
    test_perf();
`endif
    repeat (3) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
